// File: rtl/led_pkg.sv
// Shared mode encodings for the multi-channel LED blinker.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_PULSE = 2'd3
  } mode_t;

endpackage

// File: rtl/led_tick_gen.sv
// Timebase prescaler: counts 0..DIV-1 and strobes tick while the count sits at DIV-1.
module led_tick_gen #(
  parameter int CLK_HZ  = 100000000,
  parameter int TICK_HZ = 1000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt == PW'(DIV - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + PW'(1);
    end
  end

  // Decoded from the registered count; zero throughout reset because DIV >= 2.
  assign tick = (cnt == PW'(DIV - 1));

endmodule

// File: rtl/multi_led_blinker.sv
// Multi-channel LED blinker with OFF/ON/BLINK/PULSE modes on a shared tick timebase.
// Optional per-channel PWM brightness is enabled by defining LED_PWM_EN.
module multi_led_blinker
  import led_pkg::*;
#(
  parameter int CLK_HZ  = 100000000,
  parameter int TICK_HZ = 1000,
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 16,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_mode,
  input  logic [CNT_W-1:0]  cfg_half_period,
  input  logic [7:0]        cfg_duty,
  output logic [NUM_CH-1:0] led,
  output logic              tick
);

  mode_t             mode [NUM_CH];
  logic [CNT_W-1:0]  hp   [NUM_CH];
  logic [CNT_W-1:0]  cnt  [NUM_CH];
  logic [NUM_CH-1:0] state;
  logic              ready;
  logic              accept;

  function automatic logic [CNT_W-1:0] last_count(input logic [CNT_W-1:0] h);
    return (h == '0) ? '0 : h - CNT_W'(1);
  endfunction

  led_tick_gen #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign accept    = cfg_valid && ready;
  assign cfg_ready = ready;

  // Out-of-range channels never match any index, so such writes only complete the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready <= 1'b0;
      state <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        mode[i] <= MODE_OFF;
        hp[i]   <= CNT_W'(1);
        cnt[i]  <= '0;
      end
    end else begin
      ready <= !accept;
      for (int i = 0; i < NUM_CH; i++) begin
        if (accept && (cfg_ch == CH_W'(i))) begin
          mode[i]  <= mode_t'(cfg_mode);
          hp[i]    <= cfg_half_period;
          cnt[i]   <= '0;
          state[i] <= (cfg_mode != MODE_OFF);
        end else if (tick) begin
          case (mode[i])
            MODE_OFF: state[i] <= 1'b0;
            MODE_ON:  state[i] <= 1'b1;
            MODE_BLINK: begin
              if (cnt[i] == last_count(hp[i])) begin
                cnt[i]   <= '0;
                state[i] <= ~state[i];
              end else begin
                cnt[i] <= cnt[i] + CNT_W'(1);
              end
            end
            MODE_PULSE: begin
              if (cnt[i] == last_count(hp[i])) begin
                cnt[i]   <= '0;
                state[i] <= 1'b0;
                mode[i]  <= MODE_OFF;
              end else begin
                cnt[i] <= cnt[i] + CNT_W'(1);
              end
            end
            default: state[i] <= 1'b0;
          endcase
        end
      end
    end
  end

`ifdef LED_PWM_EN
  logic [7:0]        duty [NUM_CH];
  logic [7:0]        pwm_cnt;
  logic [NUM_CH-1:0] led_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
      led_q   <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        duty[i] <= 8'hFF;
      end
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
      for (int i = 0; i < NUM_CH; i++) begin
        if (accept && (cfg_ch == CH_W'(i))) begin
          duty[i] <= cfg_duty;
        end
        led_q[i] <= state[i] && (pwm_cnt < duty[i]);
      end
    end
  end

  assign led = led_q;
`else
  logic unused_duty;
  assign unused_duty = ^cfg_duty;
  assign led         = state;
`endif

endmodule

// File: tb/tb_multi_led_blinker.sv
// Self-checking bench for multi_led_blinker at CLK_HZ=1000, TICK_HZ=100 (10 clks per tick).
module tb_multi_led_blinker;

  localparam int CLK_HZ  = 1000;
  localparam int TICK_HZ = 100;
  localparam int DIV     = 10;
  localparam int NUM_CH  = 5;
  localparam int CNT_W   = 16;
  localparam int CH_W    = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch = '0;
  logic [1:0]        cfg_mode = '0;
  logic [CNT_W-1:0]  cfg_half_period = '0;
  logic [7:0]        cfg_duty = 8'hFF;
  logic [NUM_CH-1:0] led;
  logic              tick;

  always #5 clk = ~clk;

  multi_led_blinker #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ),
    .NUM_CH  (NUM_CH),
    .CNT_W   (CNT_W)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cfg_valid       (cfg_valid),
    .cfg_ready       (cfg_ready),
    .cfg_ch          (cfg_ch),
    .cfg_mode        (cfg_mode),
    .cfg_half_period (cfg_half_period),
    .cfg_duty        (cfg_duty),
    .led             (led),
    .tick            (tick)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: each channel remembers its mode, effective half-period and
  // the number of ticks seen since its last write; LED level follows from that.
  int n;
  bit m_ready;
  int m_mode [NUM_CH];
  int m_hp   [NUM_CH];
  int m_el   [NUM_CH];
  bit chk_led = 1'b1;
  int pulse_ticks;

  function automatic logic [NUM_CH-1:0] model_led();
    logic [NUM_CH-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      case (m_mode[i])
        1: r[i] = 1'b1;
        2: r[i] = ((m_el[i] / m_hp[i]) % 2) == 0;
        3: r[i] = m_el[i] < m_hp[i];
        default: r[i] = 1'b0;
      endcase
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    n = 0;
    m_ready = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_mode[i] = 0;
      m_hp[i]   = 1;
      m_el[i]   = 0;
    end
  endtask

  task automatic step();
    bit acc, tk;
    @(posedge clk);
    n++;
    acc = cfg_valid && m_ready;
    tk  = (n % DIV) == 0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (acc && (int'(cfg_ch) == i)) begin
        m_mode[i] = int'(cfg_mode);
        m_hp[i]   = (cfg_half_period == 0) ? 1 : int'(cfg_half_period);
        m_el[i]   = 0;
      end else if (tk) begin
        m_el[i]++;
      end
    end
    m_ready = !acc;
    #1;
    if (chk_led) check("led", led, model_led());
    check("tick", tick, (n % DIV) == (DIV - 1));
    check("cfg_ready", cfg_ready, m_ready);
    if (led[1] && tick) pulse_ticks++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_led", led, 0);
    check("rst_tick", tick, 0);
    check("rst_ready", cfg_ready, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
  endtask

  task automatic write(input int ch, input int mode, input int hp, input int duty);
    cfg_ch          = CH_W'(ch);
    cfg_mode        = 2'(mode);
    cfg_half_period = CNT_W'(hp);
    cfg_duty        = 8'(duty);
    cfg_valid       = 1'b1;
    step();
    cfg_valid = 1'b0;
  endtask

  typedef struct {
    int   ch;
    int   mode;
    int   hp;
    int   hold;
    logic exp;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int t1, t2, cnt, accepts;
    logic prev;
    logic [NUM_CH-1:0] snap;

    model_reset();
    #2;
    check("rst_led_init", led, 0);
    check("rst_ready_init", cfg_ready, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    check("ready_after_1clk", cfg_ready, 1);

`ifdef LED_PWM_EN
    chk_led = 1'b0;
    write(0, 1, 1, 64);
    for (int i = 0; i < 10; i++) step();
    cnt = 0;
    for (int i = 0; i < 256; i++) begin
      step();
      if (led[0]) cnt++;
    end
    check("pwm_duty64", cnt, 64);
    #3;
    rst_n = 1'b0;
    #1;
    check("pwm_rst_led", led, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
`else
    // Tick spacing after reset release.
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (tick) cnt++;
    end
    check("tick_count_100clk", cnt, 10);

    // Table of writes: expected level of the target LED right after the write applies.
    vecs[0] = '{ch: 0, mode: 2, hp: 3, hold: 40, exp: 1'b1};
    vecs[1] = '{ch: 1, mode: 1, hp: 5, hold: 12, exp: 1'b1};
    vecs[2] = '{ch: 2, mode: 3, hp: 2, hold: 35, exp: 1'b1};
    vecs[3] = '{ch: 3, mode: 2, hp: 0, hold: 25, exp: 1'b1};
    vecs[4] = '{ch: 1, mode: 0, hp: 4, hold: 12, exp: 1'b0};
    vecs[5] = '{ch: 5, mode: 1, hp: 1, hold: 12, exp: 1'b1};
    vecs[6] = '{ch: 4, mode: 2, hp: 1, hold: 30, exp: 1'b1};
    vecs[7] = '{ch: 2, mode: 1, hp: 7, hold: 5,  exp: 1'b1};
    for (int v = 0; v < 8; v++) begin
      snap = led;
      write(vecs[v].ch, vecs[v].mode, vecs[v].hp, 255);
      if (vecs[v].ch < NUM_CH) check("vec_led_bit", led[vecs[v].ch], vecs[v].exp);
      else check("vec_bad_ch_no_change", led == snap, vecs[v].exp);
      for (int i = 1; i < vecs[v].hold; i++) step();
    end

    // BLINK hp=3 on ch0: toggles every 30 clks, other LEDs dark.
    do_reset();
    write(0, 2, 3, 255);
    check("blink_rise", led[0], 1);
    prev = led[0];
    t1 = 0;
    t2 = 0;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (led[0] != prev) begin
        if (t1 == 0) t1 = i;
        else if (t2 == 0) t2 = i;
      end
      prev = led[0];
    end
    check("blink_period", t2 - t1, 30);
    check("blink_others_dark", led[NUM_CH-1:1], 0);

    // PULSE hp=2 on ch1: 2 ticks high, then stays off.
    do_reset();
    pulse_ticks = 0;
    write(1, 3, 2, 255);
    check("pulse_rise", led[1], 1);
    for (int i = 0; i < 60; i++) step();
    check("pulse_ticks_hp2", pulse_ticks, 2);
    check("pulse_self_off", led[1], 0);

    // Rewrite after one tick extends the pulse to 3 ticks.
    pulse_ticks = 0;
    write(1, 3, 2, 255);
    cnt = 0;
    while (pulse_ticks == 0 && cnt < 30) begin
      step();
      cnt++;
    end
    check("pulse_first_tick_seen", pulse_ticks, 1);
    step();
    write(1, 3, 2, 255);
    for (int i = 0; i < 60; i++) step();
    check("pulse_ticks_rewrite", pulse_ticks, 3);
    check("pulse_rewrite_off", led[1], 0);

    // Handshake: valid held 4 clks gives two accepts.
    do_reset();
    cfg_ch = 3'd2;
    cfg_mode = 2'd1;
    cfg_half_period = 16'd1;
    cfg_valid = 1'b1;
    accepts = 0;
    for (int i = 0; i < 4; i++) begin
      if (cfg_ready) accepts++;
      step();
    end
    cfg_valid = 1'b0;
    check("hold_valid_accepts", accepts, 2);
    step();
    snap = led;
    write(5, 1, 1, 255);
    for (int i = 0; i < 12; i++) step();
    check("bad_ch_no_led_change", led, snap);

    // Write coincident with a tick: counter restarts, led stays high 20 clks for hp=2.
    do_reset();
    cnt = 0;
    while (!tick && cnt < 20) begin
      step();
      cnt++;
    end
    check("tick_found", tick, 1);
    write(0, 2, 2, 255);
    cnt = 1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (led[0] && cnt == i + 1) cnt++;
    end
    check("coincident_high_clks", cnt, 20);

    // hp=0 behaves as hp=1: toggle every tick.
    write(0, 2, 0, 255);
    prev = led[0];
    t1 = 0;
    t2 = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (led[0] != prev) begin
        if (t1 == 0) t1 = i;
        else if (t2 == 0) t2 = i;
      end
      prev = led[0];
    end
    check("hp0_period", t2 - t1, 10);

    // Randomized writes against the model.
    for (int i = 0; i < 400; i++) begin
      cfg_valid       = ($urandom_range(0, 2) == 0);
      cfg_ch          = 3'($urandom_range(0, 7));
      cfg_mode        = 2'($urandom_range(0, 3));
      cfg_half_period = 16'($urandom_range(0, 4));
      cfg_duty        = 8'($urandom_range(0, 255));
      step();
    end
    cfg_valid = 1'b0;

    // Reset mid-blink clears everything immediately and leaves no residue.
    write(2, 2, 2, 255);
    for (int i = 0; i < 15; i++) step();
    #3;
    do_reset();
    for (int i = 0; i < 30; i++) step();
    check("post_reset_dark", led, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
